// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: synchroniser, integrator,
// hysteresis, edge pulses and long-press detection per channel.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous active-high reset
//   btn        raw asynchronous button inputs, one bit per channel
//   dbsig      debounced level per channel
//   rise       one-cycle pulse coincident with dbsig going 0->1
//   fall       one-cycle pulse coincident with dbsig going 1->0
//   long_press one-cycle pulse after LONG_CYC cycles of dbsig=1
//   held       high from the long_press cycle until dbsig clears
//   sync_out   second synchroniser stage
module debounce_multi #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 21,
  parameter int TH_HI    = 100000,
  parameter int TH_LO    = 50000,
  parameter int HOLD_W   = 24,
  parameter int LONG_CYC = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] dbsig,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] sync_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH_HI_C = CNT_W'(TH_HI);
  localparam logic [CNT_W-1:0] TH_LO_C = CNT_W'(TH_LO);
  localparam logic [HOLD_W-1:0] LONG_C = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] LONG_M1 = HOLD_W'(LONG_CYC - 1);

  logic [N_CH-1:0] ff1;
  logic [N_CH-1:0] ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= '0;
      ff2 <= '0;
    end else begin
      ff1 <= btn;
      ff2 <= ff1;
    end
  end

  assign sync_out = ff2;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              db_q;
    logic              db_nxt;
    logic              rise_q;
    logic              fall_q;
    logic              lp_q;
    logic              lp_nxt;
    logic              held_q;

    always_comb begin
      count_nxt = count;
      if (ff2[i] && (count != CNT_MAX)) begin
        count_nxt = count + 1'b1;
      end else if (!ff2[i] && (count != '0)) begin
        count_nxt = count - 1'b1;
      end
    end

    // Thresholds act on the current count, so the level lags the
    // counter by one edge.
    always_comb begin
      db_nxt = db_q;
      if (count > TH_HI_C) begin
        db_nxt = 1'b1;
      end else if (count < TH_LO_C) begin
        db_nxt = 1'b0;
      end
    end

    // Hold counter tracks the registered level so it starts counting
    // the edge after dbsig rises, and is cleared on the very edge that
    // dbsig drops.
    always_comb begin
      hold_nxt = hold_cnt;
      lp_nxt   = 1'b0;
      if (!db_nxt) begin
        hold_nxt = '0;
      end else if (db_q && (hold_cnt != LONG_C)) begin
        hold_nxt = hold_cnt + 1'b1;
        lp_nxt   = (hold_cnt == LONG_M1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        count    <= '0;
        hold_cnt <= '0;
        db_q     <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        lp_q     <= 1'b0;
        held_q   <= 1'b0;
      end else begin
        count    <= count_nxt;
        hold_cnt <= hold_nxt;
        db_q     <= db_nxt;
        rise_q   <= db_nxt & ~db_q;
        fall_q   <= ~db_nxt & db_q;
        lp_q     <= lp_nxt;
        held_q   <= db_nxt & (held_q | lp_nxt);
      end
    end

    assign dbsig[i]      = db_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
    assign long_press[i] = lp_q;
    assign held[i]       = held_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi.
// Small thresholds keep every scenario to a few dozen cycles.
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] dbsig;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] long_press;
  logic [3:0] held;
  logic [3:0] sync_out;

  int checks;
  int errors;

  debounce_multi #(
    .N_CH    (4),
    .CNT_W   (4),
    .TH_HI   (8),
    .TH_LO   (3),
    .HOLD_W  (5),
    .LONG_CYC(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .dbsig     (dbsig),
    .rise      (rise),
    .fall      (fall),
    .long_press(long_press),
    .held      (held),
    .sync_out  (sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    btn = 4'h0;
    repeat (40) step();
  endtask

  task automatic test_reset;
    logic [23:0] allo;
    rst = 1'b1;
    btn = 4'hF;
    for (int c = 0; c < 2; c++) begin
      step();
      allo = {dbsig, rise, fall, long_press, held, sync_out};
      checks++;
      if (allo !== 24'h0) begin
        errors++;
        $display("FAIL reset_outs: got %h want %h", allo, 24'h0);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      step();
      checks++;
      if (dbsig !== ((i >= 12) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL reset_db step %0d: got %h want %h",
                 i, dbsig, (i >= 12) ? 4'hF : 4'h0);
      end
      checks++;
      if (rise !== ((i == 12) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL reset_rise step %0d: got %h want %h",
                 i, rise, (i == 12) ? 4'hF : 4'h0);
      end
      checks++;
      if (sync_out !== ((i >= 2) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL reset_sync step %0d: got %h want %h",
                 i, sync_out, (i >= 2) ? 4'hF : 4'h0);
      end
    end
    settle();
  endtask

  task automatic test_press_ch0;
    btn = 4'h1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (dbsig !== ((i >= 12) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL press_db step %0d: got %h want %h",
                 i, dbsig, (i >= 12) ? 4'h1 : 4'h0);
      end
      checks++;
      if (rise !== ((i == 12) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL press_rise step %0d: got %h want %h",
                 i, rise, (i == 12) ? 4'h1 : 4'h0);
      end
      checks++;
      if (fall !== 4'h0) begin
        errors++;
        $display("FAIL press_fall step %0d: got %h want 0", i, fall);
      end
    end
    btn = 4'h0;
    for (int i = 1; i <= 17; i++) begin
      step();
      checks++;
      if (dbsig !== ((i < 16) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL release_db step %0d: got %h want %h",
                 i, dbsig, (i < 16) ? 4'h1 : 4'h0);
      end
      checks++;
      if (fall !== ((i == 16) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL release_fall step %0d: got %h want %h",
                 i, fall, (i == 16) ? 4'h1 : 4'h0);
      end
    end
    settle();
  endtask

  task automatic test_bounce_ch1;
    for (int r = 0; r < 6; r++) begin
      for (int h = 0; h < 10; h++) begin
        btn = (h < 5) ? 4'h2 : 4'h0;
        step();
        checks++;
        if ({dbsig, rise, fall} !== 12'h0) begin
          errors++;
          $display("FAIL bounce r%0d h%0d: got %h want 0",
                   r, h, {dbsig, rise, fall});
        end
      end
    end
    settle();
  endtask

  task automatic test_hysteresis_ch2;
    btn = 4'h4;
    repeat (20) step();
    checks++;
    if (dbsig !== 4'h4) begin
      errors++;
      $display("FAIL hyst_sat: got %h want %h", dbsig, 4'h4);
    end
    btn = 4'h0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 10) btn = 4'h4;
      checks++;
      if ({dbsig, rise, fall} !== {4'h4, 4'h0, 4'h0}) begin
        errors++;
        $display("FAIL hyst_hold step %0d: got %h want %h",
                 i, {dbsig, rise, fall}, {4'h4, 4'h0, 4'h0});
      end
    end
    btn = 4'h0;
    for (int i = 1; i <= 17; i++) begin
      step();
      checks++;
      if (fall !== ((i == 16) ? 4'h4 : 4'h0)) begin
        errors++;
        $display("FAIL hyst_refall step %0d: got %h want %h",
                 i, fall, (i == 16) ? 4'h4 : 4'h0);
      end
    end
    settle();
  endtask

  task automatic test_long_press_ch3;
    int nrise;
    int nfall;
    btn = 4'h8;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (rise !== ((i == 12) ? 4'h8 : 4'h0)) begin
        errors++;
        $display("FAIL long_rise step %0d: got %h want %h",
                 i, rise, (i == 12) ? 4'h8 : 4'h0);
      end
      checks++;
      if (long_press !== ((i == 32) ? 4'h8 : 4'h0)) begin
        errors++;
        $display("FAIL long_pulse step %0d: got %h want %h",
                 i, long_press, (i == 32) ? 4'h8 : 4'h0);
      end
      checks++;
      if (held !== ((i >= 32) ? 4'h8 : 4'h0)) begin
        errors++;
        $display("FAIL long_held step %0d: got %h want %h",
                 i, held, (i >= 32) ? 4'h8 : 4'h0);
      end
    end
    btn = 4'h0;
    for (int i = 1; i <= 17; i++) begin
      step();
      checks++;
      if (held !== ((i < 16) ? 4'h8 : 4'h0)) begin
        errors++;
        $display("FAIL long_rel_held step %0d: got %h want %h",
                 i, held, (i < 16) ? 4'h8 : 4'h0);
      end
      checks++;
      if (fall !== ((i == 16) ? 4'h8 : 4'h0)) begin
        errors++;
        $display("FAIL long_rel_fall step %0d: got %h want %h",
                 i, fall, (i == 16) ? 4'h8 : 4'h0);
      end
    end
    settle();
    nrise = 0;
    nfall = 0;
    btn = 4'h8;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 10) btn = 4'h0;
      if (rise[3]) nrise++;
      if (fall[3]) nfall++;
      checks++;
      if ({long_press, held} !== 8'h0) begin
        errors++;
        $display("FAIL short_nolong step %0d: got %h want 0",
                 i, {long_press, held});
      end
    end
    checks++;
    if ({nrise, nfall} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL short_edges: got rise=%0d fall=%0d want 1/1",
               nrise, nfall);
    end
    settle();
  endtask

  task automatic test_back_to_back;
    btn = 4'h1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 3) btn = 4'h3;
      checks++;
      if (rise !== ((i == 12) ? 4'h1 : (i == 15) ? 4'h2 : 4'h0)) begin
        errors++;
        $display("FAIL stagger_rise step %0d: got %h want %h", i, rise,
                 (i == 12) ? 4'h1 : (i == 15) ? 4'h2 : 4'h0);
      end
    end
    settle();
  endtask

  task automatic test_mid_reset;
    logic [23:0] allo;
    btn = 4'hF;
    repeat (34) step();
    checks++;
    if ({dbsig, held} !== 8'hFF) begin
      errors++;
      $display("FAIL mid_pre: got %h want %h", {dbsig, held}, 8'hFF);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    allo = {dbsig, rise, fall, long_press, held, sync_out};
    checks++;
    if (allo !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", allo, 24'h0);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (fall !== 4'h0) begin
        errors++;
        $display("FAIL mid_nofall step %0d: got %h want 0", i, fall);
      end
      checks++;
      if (rise !== ((i == 12) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL mid_rise step %0d: got %h want %h",
                 i, rise, (i == 12) ? 4'hF : 4'h0);
      end
    end
    btn = 4'h0;
    for (int i = 1; i <= 17; i++) begin
      step();
      checks++;
      if (dbsig !== ((i < 16) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL mid_rel_db step %0d: got %h want %h",
                 i, dbsig, (i < 16) ? 4'hF : 4'h0);
      end
      checks++;
      if (fall !== ((i == 16) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL mid_rel_fall step %0d: got %h want %h",
                 i, fall, (i == 16) ? 4'hF : 4'h0);
      end
      checks++;
      if (long_press !== ((i == 12) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL mid_rel_long step %0d: got %h want %h",
                 i, long_press, (i == 12) ? 4'hF : 4'h0);
      end
      checks++;
      if (held !== ((i >= 12 && i < 16) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL mid_rel_held step %0d: got %h want %h",
                 i, held, (i >= 12 && i < 16) ? 4'hF : 4'h0);
      end
    end
    settle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    btn = 4'h0;
    test_reset();
    test_press_ch0();
    test_bounce_ch1();
    test_hysteresis_ch2();
    test_long_press_ch3();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Per channel: 2-FF synchroniser, saturating up/down integrator, hysteretic debounced level, one-cycle rise/fall event pulses, long-press detection.
- Sits between the board push-buttons/switches and user logic, in the clk domain.
- Channels are fully independent; only clk and rst are shared.

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- CNT_W, 21, integrator counter width; CNT_MAX = 2^CNT_W-1.
- TH_HI, 100000, dbsig sets when count > TH_HI.
- TH_LO, 50000, dbsig clears when count < TH_LO; requires 0 < TH_LO <= TH_HI < CNT_MAX.
- HOLD_W, 24, long-press counter width.
- LONG_CYC, 10000000, cycles of continuous dbsig=1 before long_press fires; requires 1 <= LONG_CYC <= 2^HOLD_W-1.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- btn  input  N_CH  raw asynchronous button inputs.
- dbsig  output  N_CH  debounced level per channel.
- rise  output  N_CH  one-cycle pulse when dbsig goes 0->1.
- fall  output  N_CH  one-cycle pulse when dbsig goes 1->0.
- long_press  output  N_CH  one-cycle pulse after LONG_CYC cycles of continuous dbsig=1.
- held  output  N_CH  level: high from the long_press cycle until dbsig clears.
- sync_out  output  N_CH  second synchroniser stage, for the logic analyser.

Behaviour:
- Reset: rst is sampled on posedge clk. It clears ff1, ff2, count, dbsig, hold_cnt, rise, fall, long_press and held to 0 on every channel.
  - All outputs are 0 in the cycle after the rst edge.
  - No fall pulse is generated by reset, even if dbsig was 1.
  - rst has priority over all other updates.
- Synchroniser: ff1 <= btn; ff2 <= ff1; sync_out = ff2.
- Integrator, per cycle:
  - if ff2=1 and count != CNT_MAX, count+1;
  - if ff2=0 and count != 0, count-1;
  - otherwise hold. Never wraps.
- Hysteresis, registered from the current count:
  - if count > TH_HI, dbsig <= 1;
  - else if count < TH_LO, dbsig <= 0;
  - else hold.
- Latency:
  - Press: btn held stable high from count=0 → dbsig rises TH_HI+4 edges after btn rises.
  - Release: from a saturated count → dbsig falls CNT_MAX-TH_LO+4 edges after btn falls.
- Edges: rise and fall are registered in the same edge that dbsig changes, so each is coincident with the new dbsig value and lasts exactly 1 cycle. rise and fall are never high together.
- Long press:
  - hold_cnt is 0 while dbsig=0.
  - While dbsig=1 it increments each cycle, saturating at LONG_CYC.
  - long_press pulses high for 1 cycle at edge E+LONG_CYC, where E is the edge dbsig rose. held goes high in that same cycle.
  - No repeat pulse while still pressed.
  - When dbsig clears, held clears and hold_cnt returns to 0 in the same edge.
  - If released before LONG_CYC cycles, there is no long_press.
- Channel independence: simultaneous activity on any subset of channels produces the same per-channel result as activity on that channel alone.

Test Plan (N_CH=4, CNT_W=4 so CNT_MAX=15, TH_HI=8, TH_LO=3, LONG_CYC=20, HOLD_W=5):
- Reset: rst=1 for 2 cycles with btn=4'hF, then rst=0 → all outputs 0 during reset. dbsig[k] rises 12 edges after rst deasserts, with rise[k]=1 for that single cycle.
- Clean press/release on ch0: btn[0]=1 at t0 → dbsig[0] and rise[0] at edge 12; count saturates at 15. btn[0]=0 → dbsig[0]=0 and fall[0]=1 at edge 16 after release.
- Bounce rejection on ch1: alternate btn[1] 5 cycles high / 5 cycles low ×6 from count=0 → count never exceeds 8; dbsig[1], rise[1] and fall[1] stay 0.
- Hysteresis on ch2: press to saturation, then release and re-press when count=5 → dbsig[2] stays 1 with no fall pulse; count climbs back to 15.
- Long press on ch3: hold 40 cycles → long_press[3] pulses once, exactly 20 edges after rise[3]; held[3]=1 until fall[3]. A second press held 10 cycles → no long_press.
- Mid-operation reset with all channels at dbsig=1 and held=1: assert rst for 1 cycle → all outputs 0 next cycle, no fall pulses. Release all channels simultaneously from saturation → independent, identical fall timing on every channel.
